axilite_cmd_master: RTL and testbench



---
 rtl/axilite_cmd_master_if.sv | 33 +++
 rtl/axilite_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_axilite_cmd_master.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_cmd_master_if.sv
// AXI-Lite bus between the command master and a memory slave.
interface axilite_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_cmd_master.sv
// Single-outstanding command/response to AXI-Lite master bridge.
// Define AXIM_TIMEOUT_EN to enable the sticky per-state watchdog flag.
module axilite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axilite_cmd_master_if.master    m_axi,
    output logic                    timeout
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int OFF_W  = (LSB == 0) ? 1 : LSB;

    typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_t;

    state_t state;
    logic   aw_done, w_done;
    logic   cmd_acc, misaligned;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;

    always_comb begin
        cmd_acc    = (state == IDLE) && cmd_valid && cmd_ready;
        misaligned = (LSB != 0) && (cmd_addr[OFF_W-1:0] != '0);
        aw_hs      = m_axi.awvalid && m_axi.awready;
        w_hs       = m_axi.wvalid && m_axi.wready;
        b_hs       = m_axi.bvalid && m_axi.bready;
        ar_hs      = m_axi.arvalid && m_axi.arready;
        r_hs       = m_axi.rvalid && m_axi.rready;
    end

    // Bus payload is captured once at accept and then held, so it stays stable while valid.
    always_ff @(posedge s_axi_aclk) begin
        if (cmd_acc) begin
            m_axi.awaddr <= cmd_addr;
            m_axi.araddr <= cmd_addr;
            m_axi.wdata  <= cmd_wdata;
            m_axi.wstrb  <= cmd_wstrb;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        cmd_ready <= 1'b0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (misaligned) begin
                            rsp_resp  <= 2'b10;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else if (cmd_write) begin
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi.arvalid <= 1'b1;
                            state         <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    // AW and W complete independently; B is only opened once both are done.
                    if (aw_hs) begin
                        m_axi.awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi.wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi.bready <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        m_axi.rready <= 1'b0;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_resp     <= m_axi.rresp;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    // cmd_ready rises together with the return to IDLE.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_resp  <= 2'b00;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIM_TIMEOUT_EN
    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic             busy, leave;

    always_comb begin
        busy  = (state == WR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
        leave = ((state == WR) && (aw_done || aw_hs) && (w_done || w_hs)) ||
                ((state == WRESP) && b_hs) ||
                ((state == RADDR) && ar_hs) ||
                ((state == RDATA) && r_hs);
    end

    // Counter holds the cycles completed in the current wait state; it saturates at the limit.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (cmd_acc)
                timeout <= 1'b0;
            if (!busy || leave) begin
                wd_cnt <= '0;
            end else if (wd_cnt != TO_LIM) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt + 1'b1 == TO_LIM)
                    timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Directed bench for axilite_cmd_master with a reactive AXI-Lite memory slave (128 words).
module tb_axilite_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axilite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axilite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .m_axi        (bus),
        .timeout      (timeout)
    );

    // Slave control knobs, written by tests
    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit b_hold = 0;

    // Posedge monitor: handshake counters and protocol watch
    int cyc = 0, aw_hs_n = 0, w_hs_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, proto_err = 0;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    logic [3:0]  w_strb_l;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_awhs = 0, p_whs = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_awhs = 0; p_whs = 0;
        end else begin
            if (bus.arvalid && (bus.awvalid || bus.wvalid)) proto_err++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) proto_err++;
            if (p_awv && !p_awr && !bus.awvalid) proto_err++;
            if (p_wv && !p_wr && !bus.wvalid) proto_err++;
            if (p_arv && !p_arr && !bus.arvalid) proto_err++;
            if (p_awhs && bus.awvalid) proto_err++;
            if (p_whs && bus.wvalid) proto_err++;
            p_awhs = bus.awvalid && bus.awready;
            p_whs  = bus.wvalid && bus.wready;
            if (p_awhs) begin aw_hs_n++; aw_hs_cyc = cyc; aw_addr_l = bus.awaddr; end
            if (p_whs) begin w_hs_n++; w_hs_cyc = cyc; w_data_l = bus.wdata; w_strb_l = bus.wstrb; end
            if (bus.bvalid && bus.bready) b_n++;
            if (bus.arvalid && bus.arready) begin ar_n++; ar_addr_l = bus.araddr; end
            if (bus.rvalid && bus.rready) r_n++;
            p_awv = bus.awvalid; p_awr = bus.awready;
            p_wv  = bus.wvalid;  p_wr  = bus.wready;
            p_arv = bus.arvalid; p_arr = bus.arready;
        end
    end

    // Negedge slave driver
    logic [31:0] mem [0:127];
    bit mem_inited = 0;
    int aw_used = 0, w_used = 0, b_seen = 0, ar_used = 0, r_seen = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
            bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
            aw_used = aw_hs_n; w_used = w_hs_n; b_seen = b_n; ar_used = ar_n; r_seen = r_n;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            if (!mem_inited) begin
                for (int i = 0; i < 128; i++) mem[i] = 32'h0;
                mem_inited = 1;
            end
        end else begin
            if (b_n != b_seen) begin bus.bvalid = 0; b_seen = b_n; end
            if (r_n != r_seen) begin bus.rvalid = 0; r_seen = r_n; end
            if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin bus.awready = 0; aw_cnt = 0; end
            if (bus.wvalid) begin bus.wready = (w_cnt >= w_delay); w_cnt++; end
            else begin bus.wready = 0; w_cnt = 0; end
            if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin bus.arready = 0; ar_cnt = 0; end
            if (aw_hs_n != aw_used && w_hs_n != w_used && !bus.bvalid && !b_hold) begin
                if (aw_addr_l < 32'd512) begin
                    for (int i = 0; i < 4; i++)
                        if (w_strb_l[i]) mem[aw_addr_l[8:2]][8*i +: 8] = w_data_l[8*i +: 8];
                    bus.bresp = 2'b00;
                end else begin
                    bus.bresp = 2'b11;
                end
                bus.bvalid = 1; aw_used = aw_hs_n; w_used = w_hs_n;
            end
            if (ar_n != ar_used && !bus.rvalid) begin
                if (ar_addr_l < 32'd512) begin bus.rdata = mem[ar_addr_l[8:2]]; bus.rresp = 2'b00; end
                else begin bus.rdata = 32'h0; bus.rresp = 2'b11; end
                bus.rvalid = 1; ar_used = ar_n;
            end
        end
    end

    // Issue one command, wait for its response and consume it; lat counts clock edges from accept.
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic [1:0] resp, output int lat);
        int g;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (!cmd_ready) begin
            errors++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 0; rdata = 'x; resp = 'x; lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        rdata = rsp_rdata; resp = rsp_resp;
        checks++;
        if (!rsp_valid) begin errors++; $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: cmd_ready/rsp_valid/timeout=%b required 000", {cmd_ready, rsp_valid, timeout});
        end
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            errors++; $display("FAIL reset_bus: valids/readies=%b required 00000",
                {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL reset_rsp: rdata=%h resp=%b required 0/00", rsp_rdata, rsp_resp);
        end
        rstn = 1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        logic [31:0] rd; logic [1:0] rs; int lat; int b0;
        b0 = b_n;
        do_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, rs, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", lat); end
        checks++;
        if (rs !== 2'b00 || rd !== 32'h0) begin errors++; $display("FAIL wr_rsp: resp=%b rdata=%h required 00/0", rs, rd); end
        checks++;
        if (aw_addr_l !== 32'h10 || w_data_l !== 32'hDEADBEEF || w_strb_l !== 4'hF) begin
            errors++; $display("FAIL wr_bus: awaddr=%h wdata=%h wstrb=%h required 10/deadbeef/f", aw_addr_l, w_data_l, w_strb_l);
        end
        checks++;
        if (b_n - b0 !== 1) begin errors++; $display("FAIL wr_bcount: got %0d required 1", b_n - b0); end
    endtask

    task automatic test_skew();
        logic [31:0] rd; logic [1:0] rs; int lat; int b0;
        aw_delay = 2; w_delay = 0; b0 = b_n;
        do_cmd(1, 32'h14, 32'h11223344, 4'hF, rd, rs, lat);
        checks++;
        if (aw_hs_cyc - w_hs_cyc !== 2) begin errors++; $display("FAIL skew_w_first: aw-w gap %0d required 2", aw_hs_cyc - w_hs_cyc); end
        checks++;
        if (rs !== 2'b00 || b_n - b0 !== 1) begin errors++; $display("FAIL skew_w_first_b: resp=%b bcount=%0d required 00/1", rs, b_n - b0); end
        aw_delay = 0; w_delay = 2; b0 = b_n;
        do_cmd(1, 32'h18, 32'h55667788, 4'hF, rd, rs, lat);
        checks++;
        if (w_hs_cyc - aw_hs_cyc !== 2) begin errors++; $display("FAIL skew_aw_first: w-aw gap %0d required 2", w_hs_cyc - aw_hs_cyc); end
        checks++;
        if (rs !== 2'b00 || b_n - b0 !== 1 || lat !== 5) begin
            errors++; $display("FAIL skew_aw_first_b: resp=%b bcount=%0d lat=%0d required 00/1/5", rs, b_n - b0, lat);
        end
        w_delay = 0;
    endtask

    task automatic test_read_after_write();
        logic [31:0] rd; logic [1:0] rs; int lat;
        do_cmd(1, 32'h20, 32'hA5A5A5A5, 4'h3, rd, rs, lat);
        do_cmd(0, 32'h20, 32'h0, 4'h0, rd, rs, lat);
        checks++;
        if (rd !== 32'h0000A5A5 || rs !== 2'b00) begin errors++; $display("FAIL raw_read: rdata=%h resp=%b required 0000a5a5/00", rd, rs); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", lat); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] rs; int lat; int ar0, aw0;
        do_cmd(0, 32'h1000, 32'h0, 4'h0, rd, rs, lat);
        checks++;
        if (rd !== 32'h0 || rs !== 2'b11) begin errors++; $display("FAIL oor_read: rdata=%h resp=%b required 0/11", rd, rs); end
        ar0 = ar_n;
        do_cmd(0, 32'h22, 32'h0, 4'h0, rd, rs, lat);
        checks++;
        if (rs !== 2'b10 || rd !== 32'h0 || lat !== 1 || ar_n !== ar0) begin
            errors++; $display("FAIL misaligned_read: resp=%b rdata=%h lat=%0d ar=%0d required 10/0/1/%0d", rs, rd, lat, ar_n, ar0);
        end
        aw0 = aw_hs_n;
        do_cmd(1, 32'h41, 32'hFFFFFFFF, 4'hF, rd, rs, lat);
        checks++;
        if (rs !== 2'b10 || lat !== 1 || aw_hs_n !== aw0) begin
            errors++; $display("FAIL misaligned_write: resp=%b lat=%0d aw=%0d required 10/1/%0d", rs, lat, aw_hs_n, aw0);
        end
    endtask

    task automatic test_backpressure();
        int g; int bad;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; g = 0;
        while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || cmd_ready || rsp_rdata !== 32'h0000A5A5 || rsp_resp !== 2'b00) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rsp_hold: %0d unstable cycles required 0", bad); end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] rs; int lat; int g; int b0;
        b_hold = 1; b0 = b_n;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; g = 0;
        while (!bus.bready && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (bus.bready !== 1'b1) begin errors++; $display("FAIL wresp_reach: bready=%b required 1", bus.bready); end
        rstn = 0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, timeout, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 8'b0 ||
            rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL mid_reset: ctrl=%b rdata=%h resp=%b required 0/0/00",
                {cmd_ready, rsp_valid, timeout, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, rsp_rdata, rsp_resp);
        end
        b_hold = 0;
        @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || b_n !== b0) begin errors++; $display("FAIL mid_reset_norsp: rsp_valid=%b bcount=%0d required 0/%0d", rsp_valid, b_n, b0); end
        do_cmd(0, 32'h30, 32'h0, 4'h0, rd, rs, lat);
        checks++;
        if (rd !== 32'h0 || rs !== 2'b00) begin errors++; $display("FAIL abandoned_write: rdata=%h resp=%b required 0/00", rd, rs); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] rs; int lat; int g; int arv_bad; int to_bad;
        ar_delay = 20;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; arv_bad = 0; to_bad = 0;
        for (int n = 1; n <= 20; n++) begin
            if (bus.arvalid !== 1'b1) arv_bad++;
`ifdef AXIM_TIMEOUT_EN
            if (timeout !== (n >= TO + 1)) to_bad++;
`else
            if (timeout !== 1'b0) to_bad++;
`endif
            @(negedge clk);
        end
        checks++;
        if (arv_bad !== 0) begin errors++; $display("FAIL arvalid_hold: %0d low cycles required 0", arv_bad); end
        checks++;
        if (to_bad !== 0) begin errors++; $display("FAIL timeout_profile: %0d wrong cycles required 0", to_bad); end
        g = 0;
        while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000A5A5 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL slow_read: valid=%b rdata=%h resp=%b required 1/0000a5a5/00", rsp_valid, rsp_rdata, rsp_resp);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        ar_delay = 0;
`ifdef AXIM_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b required 1", timeout); end
`endif
        do_cmd(1, 32'h40, 32'h01020304, 4'hF, rd, rs, lat);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b required 0", timeout); end
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        test_reset();
        test_write_zero_wait();
        test_skew();
        test_read_after_write();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        checks++;
        if (proto_err !== 0) begin errors++; $display("FAIL axi_protocol: %0d violations required 0", proto_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end
endmodule
